// File: rtl/gpu_mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide Avalon-MM master among N render
// controllers, one transaction in flight at a time, with a read-data watchdog.
module gpu_mem_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1,
    parameter int TIMEOUT  = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [32*N-1:0]     req_address,
    input  logic [8*N-1:0]      req_writedata,
    input  logic [N-1:0]        req_write,
    input  logic [N-1:0]        req_read,
    output logic [N-1:0]        req_waitrequest,
    output logic [7:0]          req_readdata,
    output logic [N-1:0]        req_readdatavalid,
    output logic [31:0]         m_address,
    output logic [7:0]          m_writedata,
    output logic                m_write,
    output logic                m_read,
    input  logic                m_waitrequest,
    input  logic [7:0]          m_readdata,
    input  logic                m_readdatavalid,
    output logic [IDX_BITS-1:0] grant,
    output logic                timeout_error
);
    localparam int CNT_BITS = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

    state_t              state;
    logic [CNT_BITS-1:0] count;
    logic [N-1:0]        active;
    logic [IDX_BITS-1:0] winner;
    logic                owner_write;
    logic                owner_read;
    logic                data_valid;
    logic                timed_out;

    assign active      = req_read | req_write;
    assign owner_write = req_write[grant];
    assign owner_read  = req_read[grant] & ~req_write[grant];
    assign data_valid  = (state == WAIT_DATA) && m_readdatavalid;
    // The watchdog fires in the TIMEOUT-th WAIT_DATA cycle; real data in that cycle still wins.
    assign timed_out   = (state == WAIT_DATA) && !m_readdatavalid &&
                         (count == CNT_BITS'(TIMEOUT - 1));
    assign timeout_error = timed_out;

    // Walk downward so the closest active index after grant is the last one written.
    always_comb begin : rr_search
        int idx;
        idx    = 0;
        winner = grant;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(grant) + k) % N;
            if (active[idx]) begin
                winner = IDX_BITS'(idx);
            end
        end
    end

    always_comb begin
        m_address         = '0;
        m_writedata       = '0;
        m_write           = 1'b0;
        m_read            = 1'b0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        req_readdata      = '0;
        if (state == ISSUE) begin
            m_address              = req_address[32*int'(grant) +: 32];
            m_writedata            = req_writedata[8*int'(grant) +: 8];
            m_write                = owner_write;
            m_read                 = owner_read;
            req_waitrequest[grant] = m_waitrequest;
        end
        if (state == WAIT_DATA) begin
            req_readdata = timed_out ? 8'h00 : m_readdata;
            if (data_valid || timed_out) begin
                req_readdatavalid[grant] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= IDX_BITS'(N - 1);
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|active) begin
                        grant <= winner;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An owner that withdraws before acceptance simply forfeits its slot.
                    if (!active[grant]) begin
                        state <= IDLE;
                    end else if (!m_waitrequest) begin
                        if (owner_write) begin
                            state <= IDLE;
                        end else begin
                            state <= WAIT_DATA;
                            count <= '0;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (data_valid || timed_out) begin
                        state <= IDLE;
                    end else if (count != CNT_BITS'(TIMEOUT)) begin
                        count <= count + CNT_BITS'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gpu_mem_arbiter.md
# gpu_mem_arbiter

Round-robin arbiter that shares a single byte-wide Avalon-MM master port between `N` GPU render controllers, each of which drives its own byte-wide read/write master (address, writedata, write, read, waitrequest, readdata, readdatavalid). It sits between the controller tiles and the system interconnect, so several screen tiles can rasterize, shade and write out concurrently through one memory port. It allows exactly one outstanding transaction at a time. A watchdog protects against a read that never returns data.

## Interface
- `N`, 4: number of requesting controllers (≥1).
- `IDX_BITS`, `$clog2(N)` (min 1): width of the grant index.
- `TIMEOUT`, 255: cycles to wait for `m_readdatavalid` before aborting a read (≥1).
- `clock` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_address` in 32·N: per-requester address; requester i uses `[32i+:32]`.
- `req_writedata` in 8·N: per-requester write byte; `[8i+:8]`.
- `req_write` in N: per-requester write request.
- `req_read` in N: per-requester read request.
- `req_waitrequest` out N: per-requester stall.
- `req_readdata` out 8: read byte, broadcast to all requesters.
- `req_readdatavalid` out N: one-hot read-data strobe.
- `m_address` out 32: downstream address.
- `m_writedata` out 8: downstream write byte.
- `m_write` out 1: downstream write.
- `m_read` out 1: downstream read.
- `m_waitrequest` in 1: downstream stall.
- `m_readdata` in 8: downstream read byte.
- `m_readdatavalid` in 1: downstream read-data strobe.
- `grant` out IDX_BITS: index of the current or last owner.
- `timeout_error` out 1: one-cycle pulse when a read is aborted.

## Operation
- A requester is active when `req_read[i] | req_write[i]`. If both are set, the request is treated as a write and the read is ignored.
- States:
  - IDLE: if any requester is active, register the winner into `grant` and go to ISSUE; otherwise stay in IDLE.
  - ISSUE: drive `m_*` combinationally from requester `grant`.
    - `!m_waitrequest` with a write: go to IDLE.
    - `!m_waitrequest` with a read: go to WAIT_DATA and clear the timeout counter.
    - Owner drops both read and write: go to IDLE. No downstream transaction is counted.
  - WAIT_DATA: `m_read` and `m_write` are 0.
    - On `m_readdatavalid`: pulse `req_readdatavalid[grant]` and go to IDLE.
    - If the counter reaches `TIMEOUT`: pulse `req_readdatavalid[grant]` with `req_readdata` = 0, pulse `timeout_error`, and go to IDLE.
- Round-robin: search starts at `grant+1` modulo N and wraps. The winner is the first active index found. `grant` resets to N−1, so requester 0 wins first after reset.
- `req_waitrequest[i]` = 1 for every i except `grant` while in ISSUE, where it equals `m_waitrequest`. It is also 1 in IDLE and in WAIT_DATA, so a requester keeps its request held until it is granted.
- `req_readdata` = `m_readdata` in WAIT_DATA, else 0.
- `m_readdatavalid` outside WAIT_DATA is ignored (no strobe forwarded).
- `m_address`, `m_writedata`, `m_read`, `m_write` are 0 outside ISSUE.
- Timeout counter width is `$clog2(TIMEOUT+1)` and it saturates. It increments every WAIT_DATA cycle without valid.

## Timing
- Reset (`reset`=0): state IDLE, `grant`=N−1, counter 0. All outputs 0 except `req_waitrequest`, which is all ones.
- Arbitration latency: request seen in IDLE at edge k, so `m_read`/`m_write` are asserted during cycle k+1.
- Minimum write occupancy is 2 cycles (IDLE, ISSUE). Minimum read occupancy is 3 cycles (IDLE, ISSUE, WAIT_DATA with valid).
- The `m_readdatavalid` to `req_readdatavalid` path is combinational (zero latency).
- Back-to-back: after completion the next grant needs one IDLE cycle. The same requester may win again only if no other requester is active.
- Reset asserted mid-transaction aborts immediately. No strobe is delivered, and a late `m_readdatavalid` after reset is ignored (state is IDLE).
- N=1: `grant` is constant 0. Behaviour is otherwise identical.

## Test plan
- Reset, then requester 0 reads 0x100 with `m_waitrequest` low for 1 cycle. Memory returns 0x5A after 3 cycles. Expect `req_readdatavalid`=4'b0001 with `req_readdata`=0x5A. All other `req_waitrequest` bits stay 1 throughout.
- All 4 requesters write continuously (data 0x10+i). Expect the downstream write order 0,1,2,3,0,… with each `m_writedata` matching its owner. Expect exactly 2 cycles per grant.
- Requester 2 writes while `m_waitrequest` is held high for 5 cycles. Expect `m_write` to stay asserted with a stable address. `req_waitrequest[2]` mirrors `m_waitrequest`. Completion is in the cycle the stall drops.
- With `TIMEOUT`=8, requester 1 reads and `m_readdatavalid` is never asserted. Expect on cycle 8 of WAIT_DATA: `timeout_error`=1, `req_readdatavalid`=4'b0010, `req_readdata`=0. Next, requester 3's pending request is granted.
- Requester 0 sets read and write simultaneously. Expect `m_write`=1 and `m_read`=0.
- Assert `reset` in WAIT_DATA, then release. Expect IDLE and `grant`=N−1. A stray `m_readdatavalid` produces no `req_readdatavalid`.
